// File: rtl/fxp_addsub_pipe.sv
// Multi-lane, two-stage pipelined signed fixed-point add/sub with valid/ready handshake.
// Define FXP_ADDSUB_SAT_EN to saturate on overflow; the default build wraps around.
module fxp_addsub_pipe #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES-1:0]                   op,
    input  logic [LANES*(INT_W+FRAC_W)-1:0]    a,
    input  logic [LANES*(INT_W+FRAC_W)-1:0]    b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*(INT_W+FRAC_W)-1:0]    result,
    output logic [LANES-1:0]                   flag_n,
    output logic [LANES-1:0]                   flag_v,
    output logic [LANES-1:0]                   flag_z,
    input  logic                               clr_sticky,
    output logic [LANES-1:0]                   ovf_sticky
);

    localparam int W  = INT_W + FRAC_W;
    localparam int SW = W + 1;

`ifdef FXP_ADDSUB_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic                  en1_s;
    logic                  en2_s;
    logic                  handoff_s;
    logic [LANES*SW-1:0]   sum_s;
    logic [LANES*W-1:0]    res_s;
    logic [LANES-1:0]      n_s;
    logic [LANES-1:0]      v_s;
    logic [LANES-1:0]      z_s;

    logic                  v1_r;
    logic [LANES*SW-1:0]   sum1_r;
    logic                  out_valid_r;
    logic [LANES*W-1:0]    result_r;
    logic [LANES-1:0]      flag_n_r;
    logic [LANES-1:0]      flag_v_r;
    logic [LANES-1:0]      flag_z_r;
    logic [LANES-1:0]      ovf_sticky_r;

    assign en2_s     = !out_valid_r || out_ready;
    assign en1_s     = !v1_r || en2_s;
    assign handoff_s = out_valid_r && out_ready;
    assign in_ready  = en1_s;

    // Stage 1 arithmetic: sign-extend to W+1 bits so negating the most negative operand is exact.
    always_comb begin
        sum_s = {(LANES*SW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (op[i]) begin
                sum_s[i*SW +: SW] = {a[i*W+W-1], a[i*W +: W]} - {b[i*W+W-1], b[i*W +: W]};
            end else begin
                sum_s[i*SW +: SW] = {a[i*W+W-1], a[i*W +: W]} + {b[i*W+W-1], b[i*W +: W]};
            end
        end
    end

    // Stage 1 registers: valid bit and the wide per-lane sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            sum1_r <= {(LANES*SW){1'b0}};
        end else if (en1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                sum1_r <= sum_s;
            end
        end
    end

    // Stage 2: overflow detect from the two top sum bits, then clamp or wrap, then N/Z.
    always_comb begin
        res_s = {(LANES*W){1'b0}};
        n_s   = {LANES{1'b0}};
        v_s   = {LANES{1'b0}};
        z_s   = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            v_s[i] = sum1_r[i*SW+W] ^ sum1_r[i*SW+W-1];
`ifdef FXP_ADDSUB_SAT_EN
            if (v_s[i]) begin
                res_s[i*W +: W] = sum1_r[i*SW+W] ? SAT_MIN : SAT_MAX;
            end else begin
                res_s[i*W +: W] = sum1_r[i*SW +: W];
            end
`else
            res_s[i*W +: W] = sum1_r[i*SW +: W];
`endif
            n_s[i] = res_s[i*W+W-1];
            z_s[i] = (res_s[i*W +: W] == {W{1'b0}});
        end
    end

    // Stage 2 registers double as the output holding register under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {(LANES*W){1'b0}};
            flag_n_r    <= {LANES{1'b0}};
            flag_v_r    <= {LANES{1'b0}};
            flag_z_r    <= {LANES{1'b0}};
        end else if (en2_s) begin
            out_valid_r <= v1_r;
            if (v1_r) begin
                result_r <= res_s;
                flag_n_r <= n_s;
                flag_v_r <= v_s;
                flag_z_r <= z_s;
            end
        end
    end

    // Sticky overflow: a handed-off overflow beat sets, clr_sticky clears, set has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= {LANES{1'b0}};
        end else begin
            ovf_sticky_r <= (ovf_sticky_r & ~{LANES{clr_sticky}})
                          | (handoff_s ? flag_v_r : {LANES{1'b0}});
        end
    end

    assign out_valid  = out_valid_r;
    assign result     = result_r;
    assign flag_n     = flag_n_r;
    assign flag_v     = flag_v_r;
    assign flag_z     = flag_z_r;
    assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Self-checking bench for fxp_addsub_pipe (Q8.8, 4 lanes); expected values come from integer arithmetic.
module tb_fxp_addsub_pipe;

    localparam int L = 4;
    localparam int W = 16;

    typedef struct packed {
        logic [L*W-1:0] res;
        logic [L-1:0]   n;
        logic [L-1:0]   v;
        logic [L-1:0]   z;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [L-1:0]   op;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] result;
    logic [L-1:0]   flag_n;
    logic [L-1:0]   flag_v;
    logic [L-1:0]   flag_z;
    logic           clr_sticky;
    logic [L-1:0]   ovf_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    beat_t exp_q[$];

    fxp_addsub_pipe #(.INT_W(8), .FRAC_W(8), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    // Golden model: exact integer add/sub, then range check and clamp or wrap to 16 bits.
    function automatic beat_t model(input logic [L-1:0] o, input logic [L*W-1:0] aa, input logic [L*W-1:0] bb);
        beat_t r;
        int sa, sb, s, q;
        logic [15:0] rb;
        r = '0;
        for (int i = 0; i < L; i++) begin
            sa = int'($signed(aa[i*W +: W]));
            sb = int'($signed(bb[i*W +: W]));
            s  = o[i] ? sa - sb : sa + sb;
            r.v[i] = (s > 32767) || (s < -32768);
`ifdef FXP_ADDSUB_SAT_EN
            q = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
`else
            q = s;
`endif
            rb = q[15:0];
            r.res[i*W +: W] = rb;
            r.n[i] = rb[15];
            r.z[i] = (rb == 16'h0000);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if ({flag_n, flag_v, flag_z} !== 12'h000) begin n_fail++; $display("FAIL reset_flags got=%h exp=000", {flag_n, flag_v, flag_z}); end
        n_checks++; if (ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got=%h exp=0", ovf_sticky); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    // Lane0: 1.5+2.25, lane1: 0x7F00+0x0200, lane2: 0-0x8000, lane3: 0xFF80-0xFF80.
    task automatic test_directed();
        beat_t e;
        logic [63:0] exp_res;
        logic [3:0]  exp_n;
`ifdef FXP_ADDSUB_SAT_EN
        exp_res = 64'h0000_7FFF_7FFF_03C0; exp_n = 4'b0000;
`else
        exp_res = 64'h0000_8000_8100_03C0; exp_n = 4'b0110;
`endif
        op = 4'b1100;
        a  = {16'hFF80, 16'h0000, 16'h7F00, 16'h0180};
        b  = {16'hFF80, 16'h8000, 16'h0200, 16'h0240};
        e  = model(op, a, b);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_latency1 got=%b exp=0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_latency2 got=%b exp=1", out_valid); end
        n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL dir_result got=%h exp=%h", result, exp_res); end
        n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL dir_model got=%h exp=%h", result, e.res); end
        n_checks++; if (flag_v !== 4'b0110) begin n_fail++; $display("FAIL dir_v got=%b exp=0110", flag_v); end
        n_checks++; if (flag_n !== exp_n) begin n_fail++; $display("FAIL dir_n got=%b exp=%b", flag_n, exp_n); end
        n_checks++; if (flag_z !== 4'b1000) begin n_fail++; $display("FAIL dir_z got=%b exp=1000", flag_z); end
        n_checks++; if (ovf_sticky !== 4'b0000) begin n_fail++; $display("FAIL dir_sticky_pre got=%b exp=0000", ovf_sticky); end
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 4'b0110) begin n_fail++; $display("FAIL dir_sticky got=%b exp=0110", ovf_sticky); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain got=%b exp=0", out_valid); end
    endtask

    // Six beats, downstream stalls for cycles 3-5; results must come out in order, none lost.
    task automatic test_back_to_back();
        logic [63:0] av[6], bv[6];
        logic [3:0]  ov[6];
        int idx_in, got, inflight;
        bit saw_drop;
        beat_t e;
        idx_in = 0; got = 0; inflight = 0; saw_drop = 0;
        for (int k = 0; k < 6; k++) begin
            av[k] = {$urandom, $urandom}; bv[k] = {$urandom, $urandom}; ov[k] = 4'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; a = av[0]; b = bv[0]; op = ov[0];
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== ((inflight < 2) || out_ready)) begin
                n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b inflight=%0d", c, in_ready, inflight);
            end
            if (!in_ready) saw_drop = 1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 6) begin
                    n_fail++; $display("FAIL b2b_extra got=%h exp=none", result);
                end else begin
                    e = model(ov[got], av[got], bv[got]);
                    if (result !== e.res) begin n_fail++; $display("FAIL b2b_order beat=%0d got=%h exp=%h", got, result, e.res); end
                end
                got++; inflight--;
            end
            if (in_valid && in_ready) begin idx_in++; inflight++; end
            @(posedge clk); #1;
            out_ready = !((c + 1) >= 3 && (c + 1) <= 5);
            if (idx_in < 6) begin
                a = av[idx_in]; b = bv[idx_in]; op = ov[idx_in];
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", got); end
        n_checks++; if (saw_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_backpressure got=%b exp=1", saw_drop); end
    endtask

    task automatic test_sticky();
        bit seen;
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        n_checks++; if (ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL sticky_clear got=%b exp=0000", ovf_sticky); end
        out_ready = 1'b0; in_valid = 1'b1; op = 4'b0000;
        a = {48'h0, 16'h7F00}; b = {48'h0, 16'h0200};
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL sticky_wait got=timeout exp=out_valid"); end
        clr_sticky = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        n_checks++; if (ovf_sticky !== 4'b0001) begin n_fail++; $display("FAIL sticky_set_wins got=%b exp=0001", ovf_sticky); end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        n_checks++; if (ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL sticky_clear2 got=%b exp=0000", ovf_sticky); end
    endtask

    // Random traffic with random backpressure and clears, scored against the model queue.
    task automatic test_random();
        logic [3:0] m_sticky, m_next;
        beat_t e, bt;
        bit acc;
        m_sticky = 4'h0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if (ovf_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky cyc=%0d got=%b exp=%b", c, ovf_sticky, m_sticky); end
            m_next = m_sticky & ~{4{clr_sticky}};
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious got=%h exp=none", result);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, flag_n, flag_v, flag_z} !== {e.res, e.n, e.v, e.z}) begin
                        n_fail++; $display("FAIL rnd_beat cyc=%0d got=%h/%b%b%b exp=%h/%b%b%b",
                                           c, result, flag_n, flag_v, flag_z, e.res, e.n, e.v, e.z);
                    end
                    m_next = m_next | e.v;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                bt = model(op, a, b);
                exp_q.push_back(bt);
            end
            m_sticky = m_next;
            @(posedge clk); #1;
            if (c >= 380) begin
                in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
            end else begin
                if (acc || !in_valid) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    op = 4'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        a = {4{16'h7F00}} ^ {$urandom, $urandom} & {4{16'h00FF}};
                        b = {$urandom, $urandom};
                    end else begin
                        a = {$urandom, $urandom}; b = {$urandom, $urandom};
                    end
                end
                out_ready  = ($urandom_range(0, 2) != 0);
                clr_sticky = ($urandom_range(0, 15) == 0);
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_lost got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = 4'b0000;
        a = {4{16'h7F00}}; b = {4{16'h0200}};
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ovf_sticky !== 4'hF) begin n_fail++; $display("FAIL mid_sticky_pre got=%b exp=1111", ovf_sticky); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        n_checks++; if (ovf_sticky !== 4'h0) begin n_fail++; $display("FAIL mid_sticky got=%b exp=0000", ovf_sticky); end
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL mid_result got=%h exp=0", result); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost got=%b exp=0", out_valid); end
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_sticky();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
